// File: rtl/pixel_capture.sv
// pixel_capture: byte-wide camera receiver, pclk/vsync/href framing
// recovers 16-bit pixels with position and frame markers in clk domain
module pixel_capture #(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_COLS     = 640,
  parameter int MAX_ROWS     = 480,
  parameter int MIN_EDGE_GAP = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic        pclk_in,
  input  logic        vsync_in,
  input  logic        href_in,
  input  logic [7:0]  data_in,
  output logic [15:0] pixel_out,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic [9:0]  col_cnt,
  output logic [9:0]  row_cnt,
  output logic        rate_err
);

  localparam int GW = $clog2(MIN_EDGE_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_EDGE_GAP);
  localparam logic [10:0] COL_MAX = 11'(MAX_COLS);
  localparam logic [10:0] ROW_MAX = 11'(MAX_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ACTIVE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] pclk_sr;
  logic [SYNC_STAGES-1:0] vsync_sr;
  logic [SYNC_STAGES-1:0] href_sr;
  logic [7:0] data_sr [SYNC_STAGES];

  logic pclk_d;
  logic vsync_d;
  logic href_d;

  logic pclk_s;
  logic vsync_s;
  logic href_s;
  logic [7:0] data_s;

  logic strobe;
  logic vs_rise;
  logic vs_fall;
  logic hr_fall;

  logic go_active;
  logic end_frame;
  logic active;
  logic accept;
  logic in_range;

  logic [GW-1:0] gap_q;
  logic          phase_q;
  logic [7:0]    hi_q;
  logic [10:0]   col_q;
  logic [10:0]   row_q;
  logic          line_pix_q;

  assign pclk_s  = pclk_sr[SYNC_STAGES-1];
  assign vsync_s = vsync_sr[SYNC_STAGES-1];
  assign href_s  = href_sr[SYNC_STAGES-1];
  assign data_s  = data_sr[SYNC_STAGES-1];

  assign strobe  = pclk_s & ~pclk_d;
  assign vs_rise = vsync_s & ~vsync_d;
  assign vs_fall = ~vsync_s & vsync_d;
  assign hr_fall = ~href_s & href_d;

  assign active   = enable && (state_q == ACTIVE);
  assign accept   = active && strobe && href_s;
  assign in_range = (col_q < COL_MAX) && (row_q < ROW_MAX);

  // bring all external inputs into clk domain, keep one delayed copy for edges
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pclk_sr  <= '0;
      vsync_sr <= '0;
      href_sr  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
      pclk_d   <= 1'b0;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      pclk_sr  <= {pclk_sr[SYNC_STAGES-2:0], pclk_in};
      vsync_sr <= {vsync_sr[SYNC_STAGES-2:0], vsync_in};
      href_sr  <= {href_sr[SYNC_STAGES-2:0], href_in};
      data_sr[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
      pclk_d   <= pclk_s;
      vsync_d  <= vsync_s;
      href_d   <= href_s;
    end
  end

  // frame state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // frame sequencing: idle until a vsync rise, then blank/active per vsync
  always_comb begin
    state_d   = state_q;
    go_active = 1'b0;
    end_frame = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (vs_rise) state_d = BLANK;
        end
        BLANK: begin
          if (vs_fall) begin
            state_d   = ACTIVE;
            go_active = 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            state_d   = BLANK;
            end_frame = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // clk cycles since last pclk edge, saturating
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)               gap_q <= '0;
    else if (strobe)          gap_q <= '0;
    else if (gap_q < GAP_MAX) gap_q <= gap_q + GW'(1);
  end

  // byte pairing, position tracking and output strobes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q     <= 1'b0;
      hi_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      line_pix_q  <= 1'b0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      rate_err    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= go_active;
      frame_done  <= end_frame;
      if (!enable) begin
        phase_q <= 1'b0;
      end else if (go_active) begin
        phase_q    <= 1'b0;
        col_q      <= '0;
        row_q      <= '0;
        line_pix_q <= 1'b0;
        rate_err   <= 1'b0;
      end else if (active) begin
        if (strobe && (gap_q < GAP_MAX)) rate_err <= 1'b1;
        if (accept) begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            hi_q <= data_s;
          end else if (in_range) begin
            pixel_out   <= {hi_q, data_s};
            pixel_valid <= 1'b1;
            col_cnt     <= col_q[9:0];
            row_cnt     <= row_q[9:0];
            col_q       <= col_q + 11'd1;
            line_pix_q  <= 1'b1;
          end
        end else if (hr_fall) begin
          if (line_pix_q && (row_q < ROW_MAX)) row_q <= row_q + 11'd1;
          col_q      <= '0;
          phase_q    <= 1'b0;
          line_pix_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_capture.sv
// tb_pixel_capture: directed vectors for pixel_capture
// small frame geometry (4 cols x 4 rows) so limits are reachable
module tb_pixel_capture;

  logic        clk;
  logic        n_rst;
  logic        enable;
  logic        pclk_in;
  logic        vsync_in;
  logic        href_in;
  logic [7:0]  data_in;
  logic [15:0] pixel_out;
  logic        pixel_valid;
  logic        frame_start;
  logic        frame_done;
  logic [9:0]  col_cnt;
  logic [9:0]  row_cnt;
  logic        rate_err;

  pixel_capture #(
    .SYNC_STAGES (2),
    .MAX_COLS    (4),
    .MAX_ROWS    (4),
    .MIN_EDGE_GAP(4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (enable),
    .pclk_in    (pclk_in),
    .vsync_in   (vsync_in),
    .href_in    (href_in),
    .data_in    (data_in),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt),
    .rate_err   (rate_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] px;
    logic [9:0]  col;
    logic [9:0]  row;
  } vec_t;

  typedef struct {
    logic [15:0] px;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        fd;
  } cap_t;

  cap_t cap[$];
  int   fs_n = 0;
  int   fd_n = 0;
  int   checks = 0;
  int   errors = 0;

  // record every pixel strobe and frame marker
  always @(negedge clk) begin
    if (pixel_valid) cap.push_back('{pixel_out, col_cnt, row_cnt, frame_done});
    if (frame_start) fs_n++;
    if (frame_done) fd_n++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    @(negedge clk);
    data_in = b;
    pclk_in = 1'b0;
    repeat (half) @(negedge clk);
    pclk_in = 1'b1;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic send_line(input logic [7:0] start, input int n,
                           input logic [7:0] inc, input int half);
    logic [7:0] b;
    b = start;
    for (int k = 0; k < n; k++) begin
      send_byte(b, half);
      b = b + inc;
    end
  endtask

  task automatic line_begin();
    @(negedge clk);
    href_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic line_end();
    repeat (6) @(negedge clk);
    href_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (6) @(negedge clk);
    vsync_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"}, 32'(pixel_out), 32'h0);
    chk({tag, "_pv"}, 32'(pixel_valid), 32'h0);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    chk({tag, "_col"}, 32'(col_cnt), 32'h0);
    chk({tag, "_row"}, 32'(row_cnt), 32'h0);
    chk({tag, "_rerr"}, 32'(rate_err), 32'h0);
  endtask

  vec_t tbl [8];
  int c0;
  int fs0;
  int fd0;

  initial begin
    tbl[0] = '{8'h12, 8'h34, 16'h1234, 10'd0, 10'd0};
    tbl[1] = '{8'h56, 8'h78, 16'h5678, 10'd1, 10'd0};
    tbl[2] = '{8'h9A, 8'hBC, 16'h9ABC, 10'd2, 10'd0};
    tbl[3] = '{8'hDE, 8'h00, 16'hDE00, 10'd3, 10'd0};
    tbl[4] = '{8'h22, 8'h44, 16'h2244, 10'd0, 10'd1};
    tbl[5] = '{8'h66, 8'h88, 16'h6688, 10'd1, 10'd1};
    tbl[6] = '{8'hAA, 8'hCC, 16'hAACC, 10'd2, 10'd1};
    tbl[7] = '{8'hEE, 8'h10, 16'hEE10, 10'd3, 10'd1};

    n_rst    = 1'b0;
    enable   = 1'b1;
    pclk_in  = 1'b0;
    vsync_in = 1'b0;
    href_in  = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // 4x2 frame from the vector table
    c0  = cap.size();
    fs0 = fs_n;
    fd0 = fd_n;
    frame_begin();
    chk("f2_start", 32'(fs_n - fs0), 32'd1);
    for (int r = 0; r < 2; r++) begin
      line_begin();
      for (int c = 0; c < 4; c++) begin
        send_byte(tbl[r*4+c].hi, 4);
        send_byte(tbl[r*4+c].lo, 4);
      end
      line_end();
    end
    chk("f2_nodone", 32'(fd_n - fd0), 32'd0);
    frame_end();
    chk("f2_done", 32'(fd_n - fd0), 32'd1);
    chk("f2_count", 32'(cap.size() - c0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (c0 + i < cap.size()) begin
        chk($sformatf("f2_px%0d", i), 32'(cap[c0+i].px), 32'(tbl[i].px));
        chk($sformatf("f2_col%0d", i), 32'(cap[c0+i].col), 32'(tbl[i].col));
        chk($sformatf("f2_row%0d", i), 32'(cap[c0+i].row), 32'(tbl[i].row));
      end
    end

    // last strobe coincides with vsync rise
    c0  = cap.size();
    fd0 = fd_n;
    frame_begin();
    line_begin();
    send_byte(8'hA5, 4);
    @(negedge clk);
    data_in = 8'h5A;
    pclk_in = 1'b0;
    repeat (4) @(negedge clk);
    pclk_in  = 1'b1;
    vsync_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("sim_count", 32'(cap.size() - c0), 32'd1);
    if (cap.size() > c0) begin
      chk("sim_px", 32'(cap[c0].px), 32'hA55A);
      chk("sim_fd", 32'(cap[c0].fd), 32'd1);
    end
    chk("sim_done", 32'(fd_n - fd0), 32'd1);
    href_in = 1'b0;
    repeat (4) @(negedge clk);

    // odd byte count, then next line
    c0 = cap.size();
    frame_begin();
    line_begin();
    send_line(8'h11, 3, 8'h11, 4);
    line_end();
    chk("odd_count", 32'(cap.size() - c0), 32'd1);
    line_begin();
    send_line(8'h44, 2, 8'h11, 4);
    line_end();
    chk("odd_count2", 32'(cap.size() - c0), 32'd2);
    if (cap.size() >= c0 + 2) begin
      chk("odd_px0", 32'(cap[c0].px), 32'h1122);
      chk("odd_px1", 32'(cap[c0+1].px), 32'h4455);
      chk("odd_col1", 32'(cap[c0+1].col), 32'd0);
      chk("odd_row1", 32'(cap[c0+1].row), 32'd1);
    end
    frame_end();

    // line longer than MAX_COLS
    c0 = cap.size();
    frame_begin();
    line_begin();
    send_line(8'h01, 12, 8'h01, 4);
    line_end();
    chk("max_count", 32'(cap.size() - c0), 32'd4);
    if (cap.size() >= c0 + 4) begin
      chk("max_lastpx", 32'(cap[c0+3].px), 32'h0708);
      chk("max_lastcol", 32'(cap[c0+3].col), 32'd3);
    end
    chk("max_colhold", 32'(col_cnt), 32'd3);
    line_begin();
    send_line(8'h31, 2, 8'h01, 4);
    line_end();
    chk("max_next_col", 32'(col_cnt), 32'd0);
    chk("max_next_row", 32'(row_cnt), 32'd1);
    frame_end();

    // pclk faster than MIN_EDGE_GAP
    c0 = cap.size();
    frame_begin();
    chk("rate_init", 32'(rate_err), 32'd0);
    line_begin();
    send_line(8'h61, 4, 8'h01, 1);
    line_end();
    chk("rate_set", 32'(rate_err), 32'd1);
    chk("rate_count", 32'(cap.size() - c0), 32'd2);
    frame_end();
    chk("rate_hold", 32'(rate_err), 32'd1);
    fs0 = fs_n;
    frame_begin();
    chk("rate_fs", 32'(fs_n - fs0), 32'd1);
    chk("rate_clear", 32'(rate_err), 32'd0);

    // async reset mid-line
    line_begin();
    send_line(8'h71, 4, 8'h01, 1);
    repeat (6) @(negedge clk);
    chk("pre_rst_err", 32'(rate_err), 32'd1);
    n_rst = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    n_rst = 1'b1;
    c0 = cap.size();
    send_line(8'h81, 4, 8'h01, 4);
    line_end();
    chk("rst_idle", 32'(cap.size() - c0), 32'd0);

    // enable dropped mid-line
    frame_begin();
    line_begin();
    send_line(8'h21, 2, 8'h22, 4);
    send_byte(8'h65, 4);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    c0 = cap.size();
    send_line(8'h87, 3, 8'h22, 4);
    line_end();
    chk("en_nopix", 32'(cap.size() - c0), 32'd0);
    chk("en_pixhold", 32'(pixel_out), 32'h2143);
    chk("en_colhold", 32'(col_cnt), 32'd0);
    fd0 = fd_n;
    frame_end();
    chk("en_nodone", 32'(fd_n - fd0), 32'd0);
    fs0 = fs_n;
    frame_begin();
    chk("en_fs", 32'(fs_n - fs0), 32'd1);
    line_begin();
    send_line(8'hBE, 2, 8'h31, 4);
    line_end();
    chk("en_resume", 32'(cap.size() - c0), 32'd1);
    if (cap.size() > c0) begin
      chk("en_px", 32'(cap[c0].px), 32'hBEEF);
      chk("en_col", 32'(cap[c0].col), 32'd0);
      chk("en_row", 32'(cap[c0].row), 32'd0);
    end
    frame_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
